l2_input_arbiter_gen: RTL
=========================

Name: l2_input_arbiter_gen

Overview:
- Parametrised next-generation L2 input decoder: arbitrates N_CH generic request channels, a flush start request and an internal flush set/way walker, one grant per decode_en cycle.
- Registers a one-hot grant and the granted line address split into tag/set for the L2 pipeline.
- Adds a configurable flush-step priority split and an anti-starvation boost for the lowest-priority channel (CPU-request slot).

Parameters:
- N_CH, 4, number of request channels; index 0 is highest priority.
- LINE_W, 26, line-address width.
- SET_BITS, 8, set-index width; tag = LINE_W-SET_BITS upper bits.
- SETS, 256, sets walked by flush.
- WAYS, 16, ways per set.
- FLUSH_PRIO, 2, channels with index < FLUSH_PRIO outrank an ongoing flush step; the rest rank below it.
- STARVE_LIMIT, 8, blocked decode cycles before channel N_CH-1 is boosted; 0 disables boosting.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- decode_en  in  1  arbitration/update enable.
- req_valid  in  N_CH  per-channel request valid.
- req_elig  in  N_CH  per-channel external gating (credit/stall conditions); a request counts only when valid&elig.
- req_addr  in  N_CH*LINE_W  per-channel line address; channel i occupies bits [i*LINE_W +: LINE_W].
- req_ready  out  N_CH  combinational accept, one-hot or zero.
- flush_valid  in  1  flush start request.
- flush_start_ok  in  1  external gating for flush start (e.g. no outstanding reqs).
- flush_step_ok  in  1  external gating for a flush step.
- flush_ready  out  1  combinational flush-start accept.
- grant  out  N_CH  registered one-hot channel grant.
- grant_flush_start  out  1  registered.
- grant_flush_step  out  1  registered; flush_set/flush_way are the values granted.
- grant_tag  out  LINE_W-SET_BITS  registered tag of the granted channel address.
- grant_set  out  SET_BITS  registered set of the granted channel address.
- flush_set  out  SET_BITS+1  walker set counter.
- flush_way  out  $clog2(WAYS)  walker way counter.
- flush_busy  out  1  flush walk in progress.
- flush_done  out  1  one-cycle pulse when the walk completes.
- starve_boost  out  1  boost active.
- idle  out  1  combinational: decode_en and nothing granted.

Behaviour:
- Reset is asynchronous and active-high: all registered outputs, counters, flush_busy, flush_done and starve_boost go to 0.
- Reset mid-walk aborts the flush and does not pulse flush_done.
- Arbitration is combinational and active only when decode_en=1; with decode_en=0 all ready outputs are 0 and all registers hold.
- Priority order, highest first:
  - (a) Flush start: flush_valid & flush_start_ok & !flush_busy.
  - (b) Channel N_CH-1, if starve_boost=1.
  - (c) Channels 0..FLUSH_PRIO-1 with valid&elig, in index order.
  - (d) Flush step: flush_busy & flush_step_ok & flush_set<SETS.
  - (e) Channels FLUSH_PRIO..N_CH-1 with valid&elig, in index order.
  - (f) idle.
- Walk completion: with flush_busy & flush_set==SETS and decode_en, clear flush_busy, flush_set and flush_way, and pulse flush_done next cycle. This is evaluated alongside (c); it uses no grant slot.
- The winner's ready output is asserted the same cycle. On the next clk edge the winner is registered into grant/grant_flush_start/grant_flush_step, and grant_tag/grant_set are loaded from the winning channel's address.
- With no channel winner, grant_tag and grant_set load 0.
- Flush start: flush_busy←1, flush_set←0, flush_way←0.
- Flush step grant: flush_way increments. When flush_way==WAYS-1 it wraps to 0 and flush_set increments, so flush_set reaches SETS after SETS*WAYS steps.
- flush_valid while flush_busy is not accepted (flush_ready=0).
- Starvation counter:
  - Width $clog2(STARVE_LIMIT+1).
  - Increments on each decode_en cycle where channel N_CH-1 has valid&elig but is not granted; saturates at STARVE_LIMIT.
  - Clears when channel N_CH-1 is granted or its valid&elig drops.
  - starve_boost = (counter==STARVE_LIMIT) and STARVE_LIMIT≠0.
- Simultaneous events: flush start and a boosted channel both ready → flush start wins and the counter stays saturated; the boosted channel wins the next eligible cycle.

Test Plan:
- Reset with all valids high, rst held 3 cycles → grant=0, req_ready=0, flush_busy=0; first decode_en cycle after release grants channel 0.
- N_CH=4, channels 1 and 3 valid&elig, addr1=0x0ABCDEF → req_ready=4'b0010; next cycle grant=4'b0010, grant_set=0xEF, grant_tag=0x0ABCD.
- SETS=2, WAYS=2, flush start then flush_step_ok=1 with no requests → 4 consecutive step grants with (set,way) = (0,0),(0,1),(1,0),(1,1); flush_done pulses once on the 6th cycle after start; flush_busy then 0.
- During the walk, channel 1 valid (index < FLUSH_PRIO) preempts a step while channel 3 does not; the walker counters hold on the preempted cycle.
- STARVE_LIMIT=8, channel 0 valid every cycle, channel 3 valid&elig → channel 3 is granted on the 9th decode cycle; the counter then clears and channel 0 resumes.
- decode_en=0 for 5 cycles with requests pending → no ready, grant and counters hold; the starvation counter does not advance.

Source files
------------

// File: rtl/l2_input_arbiter_gen.sv
// -----------------------------------------------------------------------------
// l2_input_arbiter_gen
//
// Input decoder for the L2 pipeline. Each decode_en cycle it picks at most one
// winner among: a flush start, N_CH request channels, and a step of the
// internal flush set/way walker. The winner is registered as a one-hot grant,
// and a winning channel's line address is registered split into tag/set.
//
// Handshake: a channel request is live when req_valid & req_elig. req_ready
// (or flush_ready) is the combinational accept for the current cycle; the
// request is consumed on the clk edge where its ready is high. Ready depends
// on valid but valid must never depend on ready.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   decode_en                   arbitration/update enable
//   req_valid/req_elig/req_addr per-channel request, gating, line address
//   req_ready                   combinational one-hot channel accept
//   flush_valid/flush_start_ok  flush start request and its gating
//   flush_step_ok               gating for one walker step
//   flush_ready                 combinational flush-start accept
//   grant, grant_flush_start,
//   grant_flush_step            registered winner
//   grant_tag, grant_set        registered address of the winning channel
//   flush_set, flush_way        walker position (the next step to issue)
//   flush_busy, flush_done      walk in progress / one-cycle completion pulse
//   starve_boost                lowest-priority channel is being boosted
//   idle                        decode_en with no winner this cycle
// -----------------------------------------------------------------------------
module l2_input_arbiter_gen #(
    parameter int N_CH         = 4,
    parameter int LINE_W       = 26,
    parameter int SET_BITS     = 8,
    parameter int SETS         = 256,
    parameter int WAYS         = 16,
    parameter int FLUSH_PRIO   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         decode_en,
    input  logic [N_CH-1:0]              req_valid,
    input  logic [N_CH-1:0]              req_elig,
    input  logic [N_CH*LINE_W-1:0]       req_addr,
    output logic [N_CH-1:0]              req_ready,
    input  logic                         flush_valid,
    input  logic                         flush_start_ok,
    input  logic                         flush_step_ok,
    output logic                         flush_ready,
    output logic [N_CH-1:0]              grant,
    output logic                         grant_flush_start,
    output logic                         grant_flush_step,
    output logic [LINE_W-SET_BITS-1:0]   grant_tag,
    output logic [SET_BITS-1:0]          grant_set,
    output logic [SET_BITS:0]            flush_set,
    output logic [$clog2(WAYS)-1:0]      flush_way,
    output logic                         flush_busy,
    output logic                         flush_done,
    output logic                         starve_boost,
    output logic                         idle
);
    localparam int TAG_W = LINE_W - SET_BITS;
    localparam int SET_W = SET_BITS + 1;
    localparam int WAY_W = $clog2(WAYS);
    // Keep the counter at least one bit wide so STARVE_LIMIT=0 still elaborates.
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [SET_W-1:0] SETS_V     = SET_W'(SETS);
    localparam logic [WAY_W-1:0] WAY_LAST   = WAY_W'(WAYS - 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [N_CH-1:0]   grant_q, grant_d;
    logic              grant_flush_start_q, grant_flush_start_d;
    logic              grant_flush_step_q, grant_flush_step_d;
    logic [TAG_W-1:0]  grant_tag_q, grant_tag_d;
    logic [SET_BITS-1:0] grant_set_q, grant_set_d;
    logic [SET_W-1:0]  flush_set_q, flush_set_d;
    logic [WAY_W-1:0]  flush_way_q, flush_way_d;
    logic              flush_busy_q, flush_busy_d;
    logic              flush_done_q, flush_done_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic [N_CH-1:0]   req_act;
    logic [N_CH-1:0]   ch_win;
    logic              found;
    logic              start_req, step_req;
    logic              start_win, step_win;
    logic              walk_done;
    logic              boost;
    logic [LINE_W-1:0] win_addr;

    assign req_act = req_valid & req_elig;
    assign boost   = (STARVE_LIMIT != 0) && (starve_cnt_q == STARVE_MAX);

    // Winner selection. Priority: flush start, boosted last channel, high
    // channels (index < FLUSH_PRIO), flush step, remaining channels.
    always_comb begin
        ch_win    = '0;
        found     = 1'b0;
        start_win = 1'b0;
        step_win  = 1'b0;
        win_addr  = '0;
        start_req = flush_valid && flush_start_ok && !flush_busy_q;
        step_req  = flush_busy_q && flush_step_ok && (flush_set_q < SETS_V);
        if (decode_en) begin
            if (start_req) begin
                start_win = 1'b1;
            end else if (boost && req_act[N_CH-1]) begin
                ch_win[N_CH-1] = 1'b1;
            end else begin
                for (int i = 0; i < N_CH; i++) begin
                    if (i < FLUSH_PRIO && !found && req_act[i]) begin
                        ch_win[i] = 1'b1;
                        found     = 1'b1;
                    end
                end
                if (!found && step_req) begin
                    step_win = 1'b1;
                end else begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (i >= FLUSH_PRIO && !found && req_act[i]) begin
                            ch_win[i] = 1'b1;
                            found     = 1'b1;
                        end
                    end
                end
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (ch_win[i]) win_addr = req_addr[i*LINE_W +: LINE_W];
        end
    end

    // Completion does not consume a grant slot; it can coincide with a
    // channel grant in the same cycle.
    assign walk_done = decode_en && flush_busy_q && (flush_set_q == SETS_V);

    always_comb begin
        grant_d             = grant_q;
        grant_flush_start_d = grant_flush_start_q;
        grant_flush_step_d  = grant_flush_step_q;
        grant_tag_d         = grant_tag_q;
        grant_set_d         = grant_set_q;
        flush_set_d         = flush_set_q;
        flush_way_d         = flush_way_q;
        flush_busy_d        = flush_busy_q;
        flush_done_d        = 1'b0;
        starve_cnt_d        = starve_cnt_q;
        if (decode_en) begin
            grant_d             = ch_win;
            grant_flush_start_d = start_win;
            grant_flush_step_d  = step_win;
            grant_tag_d         = (ch_win != '0) ? win_addr[LINE_W-1:SET_BITS] : '0;
            grant_set_d         = (ch_win != '0) ? win_addr[SET_BITS-1:0] : '0;

            if (start_win) begin
                flush_busy_d = 1'b1;
                flush_set_d  = '0;
                flush_way_d  = '0;
            end else if (step_win) begin
                if (flush_way_q == WAY_LAST) begin
                    flush_way_d = '0;
                    flush_set_d = flush_set_q + 1'b1;
                end else begin
                    flush_way_d = flush_way_q + 1'b1;
                end
            end else if (walk_done) begin
                flush_busy_d = 1'b0;
                flush_set_d  = '0;
                flush_way_d  = '0;
                flush_done_d = 1'b1;
            end

            // A losing flush start leaves a saturated counter untouched, so
            // the boosted channel still wins the next eligible cycle.
            if (!req_act[N_CH-1] || ch_win[N_CH-1]) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != STARVE_MAX) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q             <= '0;
            grant_flush_start_q <= 1'b0;
            grant_flush_step_q  <= 1'b0;
            grant_tag_q         <= '0;
            grant_set_q         <= '0;
            flush_set_q         <= '0;
            flush_way_q         <= '0;
            flush_busy_q        <= 1'b0;
            flush_done_q        <= 1'b0;
            starve_cnt_q        <= '0;
        end else begin
            grant_q             <= grant_d;
            grant_flush_start_q <= grant_flush_start_d;
            grant_flush_step_q  <= grant_flush_step_d;
            grant_tag_q         <= grant_tag_d;
            grant_set_q         <= grant_set_d;
            flush_set_q         <= flush_set_d;
            flush_way_q         <= flush_way_d;
            flush_busy_q        <= flush_busy_d;
            flush_done_q        <= flush_done_d;
            starve_cnt_q        <= starve_cnt_d;
        end
    end

    assign req_ready         = ch_win;
    assign flush_ready       = start_win;
    assign grant             = grant_q;
    assign grant_flush_start = grant_flush_start_q;
    assign grant_flush_step  = grant_flush_step_q;
    assign grant_tag         = grant_tag_q;
    assign grant_set         = grant_set_q;
    assign flush_set         = flush_set_q;
    assign flush_way         = flush_way_q;
    assign flush_busy        = flush_busy_q;
    assign flush_done        = flush_done_q;
    assign starve_boost      = boost;
    assign idle              = decode_en && !start_win && !step_win && (ch_win == '0);

endmodule
